pipe_hazard_ctrl: RTL
=====================

// Module: pipe_hazard_ctrl
// PURPOSE
//  Sequencer for the ID/EX pipeline buffer: detects load-use hazards and taken branches/jumps.
//  Drives the PC/IF-ID hold, IF-ID flush and ID/EX bubble controls.
//  A bubble forces all ID/EX control inputs to 0 and aluop to NOP_ALUOP.
//  Sits between the decoder and the IF/ID and ID/EX buffers.
//  Counts stall and flush cycles for performance debug.
// PARAMETERS
//  REG_W        6       register-address width (matches rd field)
//  LOAD_STALL   1       stall cycles per load-use hazard, legal 1..7
//  FLUSH_CYCLES 2       bubble cycles after a taken branch/jump, legal 1..7
//  NOP_ALUOP    3'b011  aluop value driven during a bubble
// PORTS
//  clk          in   1      clock; state updates on posedge
//  rst_n        in   1      asynchronous, active-low reset
//  id_rs        in   REG_W  rs address of instruction in ID
//  id_rt        in   REG_W  rt address of instruction in ID
//  id_uses_rs   in   1      ID instruction reads rs
//  id_uses_rt   in   1      ID instruction reads rt
//  ex_memrd     in   1      instruction in EX is a load (ID/EX out_ctrl_memrd)
//  ex_rd        in   REG_W  destination of instruction in EX
//  br_taken     in   1      branch/jump resolved taken this cycle
//  perf_clr     in   1      synchronous clear of both perf counters
//  pc_hold      out  1      hold PC
//  ifid_hold    out  1      hold IF/ID buffer
//  ifid_flush   out  1      load NOP into IF/ID
//  idex_bubble  out  1      force ID/EX control inputs to 0 and aluop to NOP_ALUOP
//  aluop_nop    out  3      constant NOP_ALUOP, for the bubble mux
//  busy         out  1      state != IDLE
//  perf_stall   out  16     saturating count of cycles with pc_hold=1
//  perf_flush   out  16     saturating count of cycles with ifid_flush=1
// BEHAVIOUR
//  - hit = ex_memrd & ((id_uses_rs & id_rs==ex_rd) | (id_uses_rt & id_rt==ex_rd)).
//    No register is exempt from the hit check.
//  - FSM, encoded 2 bits: IDLE=00, STALL=01, FLUSH=10; 3-bit down-counter cnt.
//  - Outputs are combinational from state, cnt and the current inputs (Mealy).
//    They must settle before the negedge, when the buffers sample.
//  - IDLE, br_taken=1:
//    ifid_flush=idex_bubble=1; pc_hold=ifid_hold=0.
//    If FLUSH_CYCLES>1: go to FLUSH with cnt=FLUSH_CYCLES-1.
//  - IDLE, hit=1, br_taken=0:
//    pc_hold=ifid_hold=idex_bubble=1.
//    If LOAD_STALL>1: go to STALL with cnt=LOAD_STALL-1.
//  - IDLE, neither: all control outputs 0.
//  - STALL: pc_hold=ifid_hold=idex_bubble=1; hit is ignored.
//    cnt decrements each cycle; cnt==1 -> IDLE next cycle.
//  - FLUSH: ifid_flush=idex_bubble=1; PC is not held, so the target loads.
//    cnt decrements; cnt==1 -> IDLE next cycle. hit is ignored.
//  - Priority: br_taken > hit in every state.
//  - br_taken in STALL: flush outputs that cycle, hold=0.
//    FLUSH_CYCLES>1 -> FLUSH with cnt=FLUSH_CYCLES-1; otherwise -> IDLE.
//  - br_taken in FLUSH: same cycle outputs unchanged.
//    FLUSH_CYCLES>1 -> cnt reloads to FLUSH_CYCLES-1; otherwise -> IDLE.
//  - Perf counters: +1 per qualifying cycle, saturate at 16'hFFFF.
//    perf_clr wins over increment; result is 0 next cycle.
//  - Reset (asserted at any time, including mid-STALL/FLUSH):
//    state=IDLE, cnt=0, perf_stall=perf_flush=0.
//    While rst_n=0, pc_hold, ifid_hold, ifid_flush, idex_bubble and busy are forced to 0.
//  - Latency: 0 cycles from hit/br_taken to outputs. Total stall = LOAD_STALL cycles.
// STRUCTURE
//  - Shared package pipe_ctrl_pkg:
//    state encodings, NOP_ALUOP, REG_W, perf counter width.
//  - Sub-module sat_counter (16-bit, inc/clr, saturating), instantiated twice.
//  - Hazard compare and FSM stay inline.
// TESTING
//  1. Load-use, LOAD_STALL=1: ex_memrd=1, ex_rd=5, id_rs=5, id_uses_rs=1
//     -> hold+bubble for exactly 1 cycle; busy stays 0; perf_stall=1.
//  2. LOAD_STALL=3, same hit -> hold+bubble for 3 consecutive cycles, busy=1 for cycles 2-3;
//     no hit when id_uses_rs=0.
//  3. br_taken pulse, FLUSH_CYCLES=2 -> ifid_flush+bubble for 2 cycles, pc_hold=0;
//     perf_flush=2.
//  4. br_taken and hit in same cycle -> flush only, pc_hold=0; second br_taken in FLUSH
//     reloads cnt, giving 3 flush cycles total.
//  5. rst_n low mid-STALL (cnt=2) -> outputs 0 immediately, asynchronously; state IDLE;
//     after release, a new hit stalls normally.
//  6. Preload perf_stall to 16'hFFFE, then 3 stall cycles -> saturates at 16'hFFFF;
//     perf_clr -> 0 on the next cycle.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller.
//   state_t        : 2-bit FSM encoding (IDLE/STALL/FLUSH)
//   DEF_REG_W      : default register-address width
//   DEF_NOP_ALUOP  : default aluop value driven into ID/EX during a bubble
//   PERF_W         : width of the performance counters
//   CNT_W          : width of the stall/flush down-counter
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_STALL = 2'b01,
        ST_FLUSH = 2'b10
    } state_t;

    localparam int unsigned DEF_REG_W     = 6;
    localparam logic [2:0]  DEF_NOP_ALUOP = 3'b011;
    localparam int unsigned PERF_W        = 16;
    localparam int unsigned CNT_W         = 3;

endpackage

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// sat_counter: saturating up-counter for performance debug.
//   clk, rst_n : clock, asynchronous active-low reset (count -> 0)
//   inc        : add one this cycle (held at all-ones once reached)
//   clr        : synchronous clear, takes priority over inc
//   count      : current count
module sat_counter
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned W = PERF_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != {W{1'b1}})) begin
            count_d = count_q + {{(W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: load-use hazard / taken-branch sequencer for the ID/EX buffer.
//   clk, rst_n           : clock, asynchronous active-low reset
//   id_rs, id_rt         : source register addresses of the instruction in ID
//   id_uses_rs/rt        : ID instruction actually reads rs / rt
//   ex_memrd, ex_rd      : instruction in EX is a load, and its destination
//   br_taken             : branch/jump resolved taken this cycle
//   perf_clr             : synchronous clear of both perf counters
//   pc_hold, ifid_hold   : freeze PC and IF/ID buffer
//   ifid_flush           : load NOP into IF/ID
//   idex_bubble          : zero ID/EX controls, aluop <- aluop_nop
//   aluop_nop            : constant NOP aluop for the bubble mux
//   busy                 : FSM is not IDLE
//   perf_stall/flush     : saturating counts of hold / flush cycles
// Outputs are Mealy: they react in the same cycle as hit/br_taken so the
// buffers see them at the following negedge.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned REG_W        = DEF_REG_W,
    parameter int unsigned LOAD_STALL   = 1,
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter logic [2:0]  NOP_ALUOP    = DEF_NOP_ALUOP
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_W-1:0]  id_rs,
    input  logic [REG_W-1:0]  id_rt,
    input  logic              id_uses_rs,
    input  logic              id_uses_rt,
    input  logic              ex_memrd,
    input  logic [REG_W-1:0]  ex_rd,
    input  logic              br_taken,
    input  logic              perf_clr,
    output logic              pc_hold,
    output logic              ifid_hold,
    output logic              ifid_flush,
    output logic              idex_bubble,
    output logic [2:0]        aluop_nop,
    output logic              busy,
    output logic [PERF_W-1:0] perf_stall,
    output logic [PERF_W-1:0] perf_flush
);

    localparam logic [CNT_W-1:0] STALL_RELOAD = CNT_W'(LOAD_STALL - 1);
    localparam logic [CNT_W-1:0] FLUSH_RELOAD = CNT_W'(FLUSH_CYCLES - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             hit;
    logic             hold_c, flush_c, bubble_c;

    // No register is exempt: a load to r0 still counts as a hazard.
    assign hit = ex_memrd & ((id_uses_rs & (id_rs == ex_rd)) |
                             (id_uses_rt & (id_rt == ex_rd)));

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hold_c   = 1'b0;
        flush_c  = 1'b0;
        bubble_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (br_taken) begin
                    flush_c  = 1'b1;
                    bubble_c = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        state_d = ST_FLUSH;
                        cnt_d   = FLUSH_RELOAD;
                    end
                end else if (hit) begin
                    hold_c   = 1'b1;
                    bubble_c = 1'b1;
                    if (LOAD_STALL > 1) begin
                        state_d = ST_STALL;
                        cnt_d   = STALL_RELOAD;
                    end
                end
            end
            ST_STALL: begin
                bubble_c = 1'b1;
                if (br_taken) begin
                    // A taken branch kills the stalled instruction anyway.
                    flush_c = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        state_d = ST_FLUSH;
                        cnt_d   = FLUSH_RELOAD;
                    end else begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end
                end else begin
                    hold_c = 1'b1;
                    cnt_d  = cnt_q - 1'b1;
                    if (cnt_q == 1) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_FLUSH: begin
                flush_c  = 1'b1;
                bubble_c = 1'b1;
                if (br_taken) begin
                    if (FLUSH_CYCLES > 1) begin
                        cnt_d = FLUSH_RELOAD;
                    end else begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == 1) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // The state register already reads IDLE in reset, but a live hit or
    // br_taken would still drive IDLE outputs, so gate them with rst_n.
    assign pc_hold     = hold_c   & rst_n;
    assign ifid_hold   = hold_c   & rst_n;
    assign ifid_flush  = flush_c  & rst_n;
    assign idex_bubble = bubble_c & rst_n;
    assign busy        = (state_q != ST_IDLE) & rst_n;
    assign aluop_nop   = NOP_ALUOP;

    // Counter 0 tracks hold cycles, counter 1 tracks flush cycles.
    logic [1:0]        perf_inc;
    logic [PERF_W-1:0] perf_cnt [2];

    assign perf_inc = {ifid_flush, pc_hold};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_perf
            sat_counter #(.W(PERF_W)) u_cnt (
                .clk   (clk),
                .rst_n (rst_n),
                .inc   (perf_inc[gi]),
                .clr   (perf_clr),
                .count (perf_cnt[gi])
            );
        end
    endgenerate

    assign perf_stall = perf_cnt[0];
    assign perf_flush = perf_cnt[1];

endmodule
